// File: rtl/sprite_lb_writer_pkg.sv
// Shared video constants, FSM state and line-buffer write record for the sprite pipeline.
package sprite_lb_writer_pkg;

  localparam int unsigned LB_AW     = 9;
  localparam int unsigned VISIBLE_W = 320;
  localparam int unsigned PAL_W     = 8;
  localparam int unsigned PIX_W     = 4;
  localparam int unsigned DATA_W    = PAL_W + PIX_W;
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned LAST_PAIR = 7;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic              we;
    logic [LB_AW-1:0]  addr;
    logic [DATA_W-1:0] data;
  } lb_wr_t;

endpackage

// File: rtl/sprite_lb_writer_if.sv
// Tile-row input bus and dual line-buffer write ports of the sprite writer.
interface sprite_lb_writer_if;
  import sprite_lb_writer_pkg::*;

  logic             load;
  logic [LB_AW-1:0] xpos;
  logic [PAL_W-1:0] pal;
  logic             shr_a;
  logic             shr_b;
  logic [PIX_W-1:0] pix_a;
  logic [PIX_W-1:0] pix_b;
  lb_wr_t           wr_a;
  lb_wr_t           wr_b;
  logic             busy;
  logic             done;

  modport master (
    output load, xpos, pal, shr_a, shr_b, pix_a, pix_b,
    input  wr_a, wr_b, busy, done
  );

  modport slave (
    input  load, xpos, pal, shr_a, shr_b, pix_a, pix_b,
    output wr_a, wr_b, busy, done
  );

endinterface

// File: rtl/sprite_lb_writer_gate.sv
// Per-pixel write enable: kept by shrink, opaque colour, and on-screen address.
module lb_pixel_gate
  import sprite_lb_writer_pkg::*;
(
  input  logic             keep_i,
  input  logic [PIX_W-1:0] colour_i,
  input  logic [LB_AW-1:0] addr_i,
  output logic             we_o_c
);

  // Colour 0 is transparent; addresses at or beyond the visible width are clipped.
  always_comb begin
    we_o_c = keep_i && (colour_i != '0) && (addr_i < LB_AW'(VISIBLE_W));
  end

endmodule

// File: rtl/sprite_lb_writer.sv
// Sprite line-buffer writer: turns 8 shrunk pixel pairs per tile row into up to two writes per clock.
module sprite_lb_writer
  import sprite_lb_writer_pkg::*;
(
  input  logic               ck_i,
  input  logic               reset_i,
  sprite_lb_writer_if.slave  bus_io
);

  state_e           state_q, state_d;
  logic [LB_AW-1:0] x_q, x_d;
  logic [PAL_W-1:0] pal_q, pal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  lb_wr_t           wr_a_q, wr_a_d;
  lb_wr_t           wr_b_q, wr_b_d;
  logic             last_q, last_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [LB_AW-1:0] addr_b_c;
  logic             we_a_c;
  logic             we_b_c;

  // Port B sits one past port A only when pixel A survived the shrink.
  always_comb begin
    addr_b_c = x_q + LB_AW'(bus_io.shr_a);
  end

  lb_pixel_gate u_gate_a (
    .keep_i   (bus_io.shr_a),
    .colour_i (bus_io.pix_a),
    .addr_i   (x_q),
    .we_o_c   (we_a_c)
  );

  lb_pixel_gate u_gate_b (
    .keep_i   (bus_io.shr_b),
    .colour_i (bus_io.pix_b),
    .addr_i   (addr_b_c),
    .we_o_c   (we_b_c)
  );

  // Next-state: row sequencing, X advance and write formation.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    pal_d   = pal_q;
    cnt_d   = cnt_q;
    wr_a_d  = '0;
    wr_b_d  = '0;
    last_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus_io.load) begin
          x_d     = bus_io.xpos;
          pal_d   = bus_io.pal;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus_io.load && (cnt_q != CNT_W'(LAST_PAIR))) begin
          // Abort: the pair sampled with LOAD is dropped and the new row restarts.
          x_d   = bus_io.xpos;
          pal_d = bus_io.pal;
          cnt_d = '0;
        end else begin
          wr_a_d.we   = we_a_c;
          wr_a_d.addr = x_q;
          wr_a_d.data = {pal_q, bus_io.pix_a};
          wr_b_d.we   = we_b_c;
          wr_b_d.addr = addr_b_c;
          wr_b_d.data = {pal_q, bus_io.pix_b};
          x_d   = addr_b_c + LB_AW'(bus_io.shr_b);
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(LAST_PAIR)) begin
            last_d = 1'b1;
            if (bus_io.load) begin
              x_d   = bus_io.xpos;
              pal_d = bus_io.pal;
              cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    done_d = last_q;
    busy_d = (state_d == RUN);
  end

  // State and output registers, synchronously cleared.
  always_ff @(posedge ck_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      pal_q   <= '0;
      cnt_q   <= '0;
      wr_a_q  <= '0;
      wr_b_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      pal_q   <= pal_d;
      cnt_q   <= cnt_d;
      wr_a_q  <= wr_a_d;
      wr_b_q  <= wr_b_d;
      last_q  <= last_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus_io.wr_a = wr_a_q;
  assign bus_io.wr_b = wr_b_q;
  assign bus_io.busy = busy_q;
  assign bus_io.done = done_q;

endmodule

// File: doc/sprite_lb_writer.md
Name: sprite_lb_writer

Overview:
- Line-buffer write stage directly downstream of the horizontal shrink generator.
- Per sprite tile row, takes 8 pixel pairs (16 pixels) plus the per-pair shrink enables (generator OUTA/OUTB) and emits up to two line-buffer writes per CK.
- Advances the line-buffer X address only for pixels kept by shrink.
- Suppresses writes for transparent and off-screen pixels.

Parameters:
- VISIBLE_W, 320, first X address that is off-screen; writes at X >= VISIBLE_W suppressed.
- AW, 9, line-buffer address width; X arithmetic is modulo 2^AW.
- PAL_W, 8, palette index width.

Ports:
- CK  in  1  pixel-pair clock.
- RESET  in  1  synchronous, active-high reset.
- LOAD  in  1  start of tile row; samples XPOS and PAL.
- XPOS  in  AW  X position of the row's first kept pixel.
- PAL  in  PAL_W  palette for the row.
- SHR_A  in  1  keep-enable for the first pixel of the pair (from shrink generator OUTA).
- SHR_B  in  1  keep-enable for the second pixel of the pair (from OUTB).
- PIX_A  in  4  colour index, first pixel of the pair.
- PIX_B  in  4  colour index, second pixel of the pair.
- WE_A  out  1  write strobe, port A.
- ADDR_A  out  AW  write address, port A.
- DATA_A  out  PAL_W+4  {PAL, PIX_A}.
- WE_B  out  1  write strobe, port B.
- ADDR_B  out  AW  write address, port B.
- DATA_B  out  PAL_W+4  {PAL, PIX_B}.
- BUSY  out  1  row in progress.
- DONE  out  1  one-cycle pulse after the row's last write cycle.

Behaviour:
- Clock and reset: one clock CK. RESET is synchronous, active-high.
- Reset values: all outputs 0. State IDLE. X counter 0. Pair counter 0.

State machine:
- States: IDLE, RUN.
- IDLE, LOAD=1:
  - X <= XPOS, PAL latched, pair count <= 0.
  - Go to RUN. BUSY=1 from the next cycle.
- RUN: each cycle samples SHR_A, SHR_B, PIX_A, PIX_B as pair k = 0..7.
- After pair 7 is sampled: go to IDLE, BUSY=0 next cycle. DONE pulses in the cycle after the pair-7 write outputs are presented.

Per-pair address and write rules (pair sampled in cycle t, outputs registered, valid in t+1):
- ADDR_A = X.
- ADDR_B = X + SHR_A (mod 2^AW).
- X advances by SHR_A + SHR_B (0, 1 or 2), modulo 2^AW.
- WE_A = SHR_A & (PIX_A != 0) & (ADDR_A < VISIBLE_W). WE_B uses the same rule with B terms.
- Transparent (colour 0) or clipped pixels still advance X when kept.
- Dropped pixels (SHR=0) do not advance X, and their WE is 0.
- WE_x=0 → the corresponding ADDR_x/DATA_x are don't-care, but are still driven deterministically.
- Wrap-around: X = 2^AW-1 plus 1 → 0. Pixels at X >= 2^AW-VISIBLE_W... past 511 reappear at 0 and are written if < VISIBLE_W.

Timing:
- Latency: LOAD at cycle n → pairs sampled n+1..n+8 → writes presented n+2..n+9.
- DONE = 1 at n+10.
- Throughput: back-to-back rows allowed. LOAD in the same cycle pair 7 is sampled starts the next row with no bubble. DONE still pulses for the completed row.

Boundary conditions:
- LOAD while RUN, before pair 7: current row aborted, no DONE for it. New row restarts at pair 0 with the new XPOS/PAL. The pair sampled in the LOAD cycle is discarded (WE=0 next cycle).
- RESET mid-row: outputs 0 next cycle. No DONE. LOAD in the same cycle as RESET is ignored.
- SHR inputs are ignored in IDLE; WE stays 0.

Decomposition:
- Shared video package:
  - constants LB_AW=9, VISIBLE_W=320, PAL_W=8;
  - state enum {IDLE, RUN};
  - line-buffer write record type (we, addr, data).
- One sub-module, lb_pixel_gate: pure function of (keep, colour, addr) → we. Instantiated twice for ports A and B.

Test Plan:
- XPOS=10, PAL=0x12, all SHR=1, all PIX=5 → 16 writes at 10..25, DATA=0x125, 2 per cycle from n+2. DONE at n+10.
- Shrink pattern 0 (only pair 4 has SHR_A=1) with XPOS=100 → exactly one write, ADDR_A=100 at n+6. All other WE=0. X ends at 101.
- XPOS=318, all kept, PIX=7 → writes at 318 and 319 only. Addresses 320..333 issued with WE=0.
- XPOS=510, all kept → 510 and 511 suppressed (clipped); writes at 0..13. Pair 3 PIX_A=0 → ADDR 4 not written, X still advances.
- LOAD at n, second LOAD at n+4 with XPOS=200 → first row's writes stop after pair 2. No DONE at n+10. Second row writes from 200; DONE at n+14.
- RESET asserted at n+5 during a full row → all WE=0, BUSY=0 at n+6. No DONE. A LOAD afterwards behaves as from a clean reset.
